// File: rtl/usb_tx_pkg.sv
// Constants shared by the USB full-speed transmitter and receiver:
// PIDs, sync pattern, CRC16 parameters and the transmitter state type.
package usb_tx_pkg;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_SOF   = 8'hA5;
  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // Polynomial and residual are in conventional (MSB-first) notation.
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_CRC,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_e;

  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15 - i];
    return r;
  endfunction

endpackage

// File: rtl/usb_tx_crc16.sv
// Serial USB CRC16, one data bit per enable; the register runs in reflected
// form so the complemented result can be shifted out LSB first.
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clock48,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  localparam logic [15:0] POLY_REFL = reflect16(CRC16_POLY);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[0] ^ bit_i;
    if (clear_i) begin
      crc_d = CRC16_INIT;
    end else if (enable_i) begin
      crc_d = {1'b0, crc_q[15:1]} ^ (fb ? POLY_REFL : 16'h0000);
    end
  end

  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) crc_q <= '0;
    else          crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/usb_tx.sv
// USB full-speed packet transmitter: sync, NRZI with bit stuffing, optional
// CRC16 trailer and EOP, fed one byte at a time through a valid/ready pulse.
module usb_tx
  import usb_tx_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 4
) (
  input  logic       clock48,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  input  logic       in_crc16,
  output logic       in_ready,
  output logic       usb_dp,
  output logic       usb_dn,
  output logic       usb_oe,
  output logic       busy,
  output logic       underrun
);

  localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d, idx_nxt;
  logic [7:0]       byte_q, byte_d;
  logic             last_q, last_d;
  logic             crc_en_q, crc_en_d;
  logic             pid_q, pid_d;
  logic             level_q, level_d;
  logic [2:0]       ones_q, ones_d;
  logic             strobe, send, send_bit, crc_clr, crc_step;
  logic             ready_c, underrun_c;
  logic [15:0]      crc;

  usb_crc16 u_crc16 (
    .clock48  (clock48),
    .reset_n  (reset_n),
    .clear_i  (crc_clr),
    .enable_i (crc_step),
    .bit_i    (send_bit),
    .crc_o    (crc)
  );

  // level_q is the NRZI line level of the bit on the wire (1 = J); every
  // strobe decides the next bit: sync, data, stuff, CRC or an EOP symbol.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    byte_d     = byte_q;
    last_d     = last_q;
    crc_en_d   = crc_en_q;
    pid_d      = pid_q;
    level_d    = level_q;
    ones_d     = ones_q;
    send       = 1'b0;
    send_bit   = 1'b0;
    crc_clr    = 1'b0;
    ready_c    = 1'b0;
    underrun_c = 1'b0;
    idx_nxt    = idx_q + 4'd1;
    strobe     = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);

    if (state_q == ST_IDLE) begin
      cnt_d   = '0;
      level_d = 1'b1;
      ones_d  = '0;
      if (in_valid) begin
        ready_c  = 1'b1;
        byte_d   = in_data;
        last_d   = in_last;
        crc_en_d = in_crc16;
        pid_d    = 1'b1;
        crc_clr  = 1'b1;
        state_d  = ST_SYNC;
        idx_d    = '0;
        send     = 1'b1;
        send_bit = SYNC_BYTE[0];
      end
    end else begin
      cnt_d = strobe ? '0 : cnt_q + CNT_W'(1);
      if (strobe) begin
        case (state_q)
          ST_SYNC: begin
            send = 1'b1;
            if (idx_q != 4'd7) begin
              idx_d    = idx_nxt;
              send_bit = SYNC_BYTE[idx_nxt[2:0]];
            end else begin
              state_d  = ST_DATA;
              idx_d    = '0;
              send_bit = byte_q[0];
            end
          end
          ST_DATA, ST_CRC: begin
            if (ones_q == 3'd6) begin
              level_d = ~level_q;
              ones_d  = '0;
            end else if (state_q == ST_CRC) begin
              if (idx_q != 4'd15) begin
                idx_d    = idx_nxt;
                send     = 1'b1;
                send_bit = ~crc[idx_nxt];
              end else begin
                state_d = ST_EOP_SE0;
                idx_d   = '0;
              end
            end else if (idx_q != 4'd7) begin
              idx_d    = idx_nxt;
              send     = 1'b1;
              send_bit = byte_q[idx_nxt[2:0]];
            end else if (last_q) begin
              idx_d = '0;
              if (crc_en_q) begin
                state_d  = ST_CRC;
                send     = 1'b1;
                send_bit = ~crc[0];
              end else begin
                state_d = ST_EOP_SE0;
              end
            end else if (in_valid) begin
              ready_c  = 1'b1;
              byte_d   = in_data;
              last_d   = in_last;
              pid_d    = 1'b0;
              idx_d    = '0;
              send     = 1'b1;
              send_bit = in_data[0];
            end else begin
              underrun_c = 1'b1;
              state_d    = ST_EOP_SE0;
              idx_d      = '0;
            end
          end
          ST_EOP_SE0: begin
            if (idx_q == 4'd0) begin
              idx_d = 4'd1;
            end else begin
              state_d = ST_EOP_J;
              level_d = 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    if (send) begin
      level_d = send_bit ? level_q : ~level_q;
      ones_d  = send_bit ? ones_q + 3'd1 : 3'd0;
    end
  end

  // The PID byte is excluded from the CRC.
  assign crc_step = send && (state_d == ST_DATA) && !pid_d;

  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
      last_q   <= 1'b0;
      crc_en_q <= 1'b0;
      pid_q    <= 1'b0;
      level_q  <= 1'b1;
      ones_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      last_q   <= last_d;
      crc_en_q <= crc_en_d;
      pid_q    <= pid_d;
      level_q  <= level_d;
      ones_q   <= ones_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign usb_oe   = busy;
  assign usb_dp   = level_q & (state_q != ST_EOP_SE0);
  assign usb_dn   = ~level_q & (state_q != ST_EOP_SE0);
  assign in_ready = ready_c & reset_n;
  assign underrun = underrun_c & reset_n;

endmodule

// File: tb/tb_usb_tx.sv
// Self-checking bench for usb_tx: directed packets plus random packets,
// compared cycle by cycle against a bit-level line model built from bytes.
module tb_usb_tx;

  localparam int CPB = 4;
  localparam logic [1:0] SYM_J = 2'b10, SYM_K = 2'b01, SYM_SE0 = 2'b00;

  logic       clock48 = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0, in_last = 1'b0, in_crc16 = 1'b0;
  logic       in_ready, usb_dp, usb_dn, usb_oe, busy, underrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] pkt[$];
  logic [7:0] exp_bytes[$];
  logic [1:0] exp_sym[$];
  logic [5:0] rec[$];        // {underrun, in_ready, busy, oe, dp, dn}
  logic [7:0] last_got[$];
  int         last_oe_cyc;

  always #5 clock48 = ~clock48;

  usb_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clock48  (clock48),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_crc16 (in_crc16),
    .in_ready (in_ready),
    .usb_dp   (usb_dp),
    .usb_dn   (usb_dn),
    .usb_oe   (usb_oe),
    .busy     (busy),
    .underrun (underrun)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bytes -> bit stream -> NRZI symbols with stuffing -> EOP.
  task automatic build_model(input bit with_crc, input bit starve);
    logic [7:0]  sync;
    logic [15:0] c;
    logic        lvl;
    int          ones;
    bit          bits[$];
    sync = 8'h80;
    exp_bytes.delete();
    exp_sym.delete();
    foreach (pkt[i]) exp_bytes.push_back(pkt[i]);
    if (with_crc && !starve) begin
      c = 16'hFFFF;
      for (int i = 1; i < pkt.size(); i++) begin
        c = c ^ {8'h00, pkt[i]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      c = ~c;
      exp_bytes.push_back(c[7:0]);
      exp_bytes.push_back(c[15:8]);
    end
    for (int b = 0; b < 8; b++) bits.push_back(sync[b]);
    foreach (exp_bytes[i]) for (int b = 0; b < 8; b++) bits.push_back(exp_bytes[i][b]);
    lvl = 1'b1;
    ones = 0;
    foreach (bits[i]) begin
      if (!bits[i]) begin lvl = ~lvl; ones = 0; end
      else ones++;
      exp_sym.push_back(lvl ? SYM_J : SYM_K);
      if (ones == 6) begin
        lvl = ~lvl;
        ones = 0;
        exp_sym.push_back(lvl ? SYM_J : SYM_K);
      end
    end
    exp_sym.push_back(SYM_SE0);
    exp_sym.push_back(SYM_SE0);
    exp_sym.push_back(SYM_J);
  endtask

  task automatic drive(input int k, input bit with_crc, input bit starve, input bit chain_next);
    in_crc16 = with_crc;
    if (k < pkt.size()) begin
      in_valid = 1'b1;
      in_data  = pkt[k];
      in_last  = (k == pkt.size() - 1) && !starve;
    end else if (chain_next) begin
      in_valid = 1'b1;
      in_data  = 8'hD2;
      in_last  = 1'b1;
      in_crc16 = 1'b0;
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic run_pkt(input bit with_crc, input bit starve, input bit chained,
                         input bit chain_next, input string name);
    int consumed, a, n, oe_cyc, rdy_cnt, ur_cnt, ur_at, se0_at, mism, k, c, ones, bitpos;
    bit seen_oe, done;
    logic [3:0] e;
    logic [5:0] s;
    logic [7:0] shreg;
    logic prev, d;
    logic [7:0] got[$];
    rec.delete();
    build_model(with_crc, starve);
    consumed = chained ? 1 : 0;
    @(posedge clock48); #1;
    drive(consumed, with_crc, starve, chain_next);
    seen_oe = 0;
    done = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clock48);
      rec.push_back({underrun, in_ready, busy, usb_oe, usb_dp, usb_dn});
      if (in_ready) consumed++;
      if (usb_oe) seen_oe = 1;
      else if (seen_oe) done = 1;
      if (!done) begin
        @(posedge clock48); #1;
        drive(consumed, with_crc, starve, chain_next);
      end
    end
    check({name, " completed"}, done, 1);

    n = exp_sym.size();
    a = chained ? -1 : 0;
    mism = 0; oe_cyc = 0; rdy_cnt = 0; ur_cnt = 0; ur_at = -1; se0_at = -1;
    foreach (rec[i]) begin
      k = i - a - 1;
      e = (k >= 0 && k < n * CPB) ? {2'b11, exp_sym[k / CPB]} : 4'b0010;
      if (rec[i][3:0] !== e) mism++;
      if (rec[i][2]) oe_cyc++;
      if (rec[i][4] && i != rec.size() - 1) rdy_cnt++;
      if (rec[i][5]) begin ur_cnt++; ur_at = i; end
      if (se0_at < 0 && rec[i][2:0] == 3'b100) se0_at = i;
    end
    check({name, " line_mismatch_cycles"}, mism, 0);
    check({name, " oe_cycles"}, oe_cyc, n * CPB);
    check({name, " in_ready_count"}, rdy_cnt, pkt.size() - (chained ? 1 : 0));
    check({name, " accept_after_idle"}, rec[rec.size() - 1][4], chain_next);
    check({name, " underrun_count"}, ur_cnt, starve);
    if (starve) check({name, " underrun_before_se0"}, ur_at + 1, se0_at);

    prev = 1'b1; ones = 0; bitpos = 0; shreg = '0;
    for (int b = 0; b < n; b++) begin
      c = a + 1 + b * CPB + CPB / 2;
      if (c >= rec.size()) break;
      s = rec[c];
      if (!s[2] || s[1:0] == 2'b00) break;
      d = (s[1] == prev);
      prev = s[1];
      if (ones == 6) begin ones = 0; continue; end
      ones = d ? ones + 1 : 0;
      if (bitpos >= 8) begin
        shreg = {d, shreg[7:1]};
        if ((bitpos % 8) == 7) got.push_back(shreg);
      end
      bitpos++;
    end
    check({name, " decoded_count"}, got.size(), exp_bytes.size());
    foreach (exp_bytes[i])
      check({name, " decoded_byte"}, (i < got.size()) ? {24'h0, got[i]} : 32'h100, exp_bytes[i]);
    last_got = got;
    last_oe_cyc = oe_cyc;
    $display("packet %s bytes=%0d crc=%0b starve=%0b symbols=%0d oe_cycles=%0d", name,
             pkt.size(), with_crc, starve, n, oe_cyc);
  endtask

  initial begin
    int nb;
    bit st, cr;
    // Reset state with a pending byte offered.
    in_valid = 1'b1; in_data = 8'hD2; in_last = 1'b1;
    repeat (3) @(posedge clock48);
    @(negedge clock48); #1;
    check("reset oe", usb_oe, 0);
    check("reset dp", usb_dp, 1);
    check("reset dn", usb_dn, 0);
    check("reset busy", busy, 0);
    check("reset in_ready", in_ready, 0);
    check("reset underrun", underrun, 0);
    reset_n = 1'b1;
    #1 check("release in_ready", in_ready, 1);
    @(posedge clock48); #1;
    check("first edge busy", busy, 1);
    check("first edge dp", usb_dp, 0);
    check("first edge dn", usb_dn, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 200 && busy; i++) @(negedge clock48);
    check("first packet done", busy, 0);

    pkt.delete(); pkt.push_back(8'hD2);
    run_pkt(0, 0, 0, 0, "ack");
    check("ack oe_76", last_oe_cyc, 76);

    pkt.delete(); pkt.push_back(8'hFF);
    run_pkt(0, 0, 0, 0, "stuff_ff");
    check("stuff_ff oe_80", last_oe_cyc, 80);
    check("stuff_ff byte", last_got.size() > 0 ? {24'h0, last_got[0]} : 32'h100, 8'hFF);

    pkt.delete(); pkt.push_back(8'h4B);
    run_pkt(1, 0, 0, 0, "data1_zlp");
    check("zlp count", last_got.size(), 3);
    check("zlp byte1", last_got.size() > 1 ? {24'h0, last_got[1]} : 32'h100, 8'h00);
    check("zlp byte2", last_got.size() > 2 ? {24'h0, last_got[2]} : 32'h100, 8'h00);

    pkt.delete(); pkt.push_back(8'hC3);
    run_pkt(1, 1, 0, 0, "underrun");

    // Reset in the middle of the first data byte.
    @(posedge clock48); #1;
    in_valid = 1'b1; in_data = 8'hC3; in_last = 1'b0; in_crc16 = 1'b1;
    repeat (45) @(posedge clock48);
    @(negedge clock48);
    check("mid busy before reset", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid reset oe", usb_oe, 0);
    check("mid reset dp", usb_dp, 1);
    check("mid reset dn", usb_dn, 0);
    check("mid reset busy", busy, 0);
    check("mid reset in_ready", in_ready, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clock48);
    #1 reset_n = 1'b1;
    pkt.delete(); pkt.push_back(8'hC3); pkt.push_back(8'hA5); pkt.push_back(8'h5A);
    run_pkt(1, 0, 0, 0, "after_reset");

    pkt.delete(); pkt.push_back(8'hC3); pkt.push_back(8'h12); pkt.push_back(8'h34);
    run_pkt(1, 0, 0, 1, "b2b_first");
    pkt.delete(); pkt.push_back(8'hD2);
    run_pkt(0, 0, 1, 0, "b2b_second");

    for (int p = 0; p < 20; p++) begin
      pkt.delete();
      st = ($urandom_range(0, 5) == 0);
      cr = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++)
        pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      run_pkt(cr, st, 0, 0, $sformatf("rand%0d", p));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
